// File: rtl/vehicle_counter.sv
// vehicle_counter: four independent debounced vehicle-presence counters (clk, rst, sensor[3:0] in; count_*_4b mod 16, car_pulse[3:0] out)
module vehicle_counter #(
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor,
  output logic [3:0] count_ns_4b,
  output logic [3:0] count_sn_4b,
  output logic [3:0] count_ew_4b,
  output logic [3:0] count_we_4b,
  output logic [3:0] car_pulse
);
  localparam logic [1:0] IDLE = 2'd0, RISE_WAIT = 2'd1, PRESENT = 2'd2, FALL_WAIT = 2'd3;
  localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);
  logic [3:0] s1, s2;
  logic [1:0] state [4];
  logic [7:0] stab [4];
  logic [3:0] cnt [4];
  always_ff @(posedge clk) begin
    s1 <= rst ? 4'd0 : sensor;
    s2 <= rst ? 4'd0 : s1;
  end
  for (genvar c = 0; c < 4; c++) begin : ch
    // With DEBOUNCE=1 the FSM reacts to the level arriving at s2 on this edge, giving one-edge latency.
    logic lvl;
    assign lvl = (DEBOUNCE == 1) ? s1[c] : s2[c];
    always_ff @(posedge clk) begin
      if (rst) begin
        state[c] <= IDLE;
        stab[c] <= 8'd0;
        cnt[c] <= 4'd0;
        car_pulse[c] <= 1'b0;
      end else begin
        car_pulse[c] <= 1'b0;
        case (state[c])
          IDLE:
            if (lvl) begin
              if (DEBOUNCE == 1) begin
                state[c] <= PRESENT;
                cnt[c] <= cnt[c] + 4'd1;
                car_pulse[c] <= 1'b1;
              end else begin
                state[c] <= RISE_WAIT;
                stab[c] <= 8'd1;
              end
            end
          RISE_WAIT:
            if (!lvl) begin
              state[c] <= IDLE;
              stab[c] <= 8'd0;
            end else if (stab[c] == LAST) begin
              state[c] <= PRESENT;
              cnt[c] <= cnt[c] + 4'd1;
              car_pulse[c] <= 1'b1;
            end else stab[c] <= stab[c] + 8'd1;
          PRESENT:
            if (!lvl) begin
              state[c] <= (DEBOUNCE == 1) ? IDLE : FALL_WAIT;
              stab[c] <= (DEBOUNCE == 1) ? 8'd0 : 8'd1;
            end
          default:
            if (lvl) begin
              state[c] <= PRESENT;
              stab[c] <= 8'd0;
            end else if (stab[c] == LAST) begin
              state[c] <= IDLE;
              stab[c] <= 8'd0;
            end else stab[c] <= stab[c] + 8'd1;
        endcase
      end
    end
  end
  assign count_ns_4b = cnt[0];
  assign count_sn_4b = cnt[1];
  assign count_ew_4b = cnt[2];
  assign count_we_4b = cnt[3];
endmodule

// File: tb/tb_vehicle_counter.sv
// tb_vehicle_counter: table-driven and scoreboard check of vehicle_counter with DEBOUNCE=4
module tb_vehicle_counter;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sensor = 4'b0000;
  logic [3:0] count_ns_4b, count_sn_4b, count_ew_4b, count_we_4b, car_pulse;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int q [4][$];
  logic [3:0] exp_cnt [4];
  logic [15:0] all_cnt;
  typedef struct {
    string name;
    logic [3:0] mask;
    int hi;
    int lo;
    int reps;
    logic [3:0] counted;
  } vec_t;
  vec_t vecs [5];

  vehicle_counter #(.DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst), .sensor(sensor),
    .count_ns_4b(count_ns_4b), .count_sn_4b(count_sn_4b),
    .count_ew_4b(count_ew_4b), .count_we_4b(count_we_4b),
    .car_pulse(car_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign all_cnt = {count_we_4b, count_ew_4b, count_sn_4b, count_ns_4b};

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(logic [3:0] m, int at);
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        q[i].push_back(at);
        exp_cnt[i] = exp_cnt[i] + 4'd1;
      end
  endtask

  task automatic verify(string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s count ch%0d", tag, i), 32'(all_cnt[i*4 +: 4]), 32'(exp_cnt[i]));
      check($sformatf("%s missing pulses ch%0d", tag, i), q[i].size(), 0);
    end
  endtask

  // Scoreboard: every observed pulse must match the next expected cycle for its channel.
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 4; i++)
        if (car_pulse[i]) begin
          if (q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected pulse ch%0d: got pulse at cycle %0d expected none", i, cyc);
          end else check($sformatf("pulse time ch%0d", i), cyc, q[i].pop_front());
        end

  initial begin
    int p;
    vecs[0] = '{"glitch", 4'b0001, 3, 8, 1, 4'b0000};
    vecs[1] = '{"min_high", 4'b0001, 4, 8, 1, 4'b0001};
    vecs[2] = '{"wrap", 4'b0100, 6, 6, 17, 4'b0100};
    vecs[3] = '{"pair", 4'b1001, 8, 8, 1, 4'b1001};
    vecs[4] = '{"all", 4'b1111, 5, 8, 1, 4'b1111};
    for (int i = 0; i < 4; i++) exp_cnt[i] = 4'd0;
    sensor = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      check("reset counts", all_cnt, 0);
      check("reset pulse", car_pulse, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_pulse(4'b1111, cyc + D + 2);
    tick(10);
    sensor = 4'b0000;
    tick(12);
    verify("release");
    foreach (vecs[v])
      for (int r = 0; r < vecs[v].reps; r++) begin
        sensor = vecs[v].mask;
        expect_pulse(vecs[v].counted, cyc + D + 2);
        tick(vecs[v].hi);
        sensor = 4'b0000;
        tick(vecs[v].lo);
        if (r == vecs[v].reps - 1) verify(vecs[v].name);
      end
    sensor = 4'b0010;
    expect_pulse(4'b0010, cyc + D + 2);
    tick(20);
    sensor = 4'b0000;
    tick(2);
    sensor = 4'b0010;
    tick(20);
    sensor = 4'b0000;
    tick(10);
    verify("dropout");
    sensor = 4'b1001;
    p = cyc;
    expect_pulse(4'b1001, p + D + 2);
    tick(2);
    sensor = 4'b1101;
    expect_pulse(4'b0100, p + D + 4);
    tick(10);
    sensor = 4'b0000;
    tick(12);
    verify("staggered");
    sensor = 4'b1000;
    tick(4);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 4'd0;
    tick(1);
    check("mid reset counts", all_cnt, 0);
    check("mid reset pulse", car_pulse, 0);
    rst = 1'b0;
    expect_pulse(4'b1000, cyc + D + 2);
    tick(12);
    sensor = 4'b0000;
    tick(12);
    verify("mid_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
